// File: rtl/simd_ins_sequencer.sv
// SIMD instruction sequencer: fetch, decode and issue one vector row per cycle to the PE array.
// Latency: start -> first row issue in 4 cycles; NOP/len=0 cost 4 cycles, vector op 3+len+PIPE_LAT.
// Backpressure: stall freezes all sequencing (only the WAIT capture proceeds); issue outputs drop.
module simd_ins_sequencer #(
  parameter int PE_COUNT       = 4,
  parameter int INS_WIDTH      = 64,
  parameter int INS_ADDR_WIDTH = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int OP_WIDTH       = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int PIPE_LAT       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic                      stall,
  output logic                      ins_rd_en,
  output logic [INS_ADDR_WIDTH-1:0] ins_rd_addr,
  input  logic [INS_WIDTH-1:0]      ins_rd_data,
  output logic                      op_valid,
  output logic [OP_WIDTH-1:0]       op_code,
  output logic [ADDR_WIDTH-1:0]     addr_a,
  output logic [ADDR_WIDTH-1:0]     addr_b,
  output logic [ADDR_WIDTH-1:0]     addr_r,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap_err,
  output logic [INS_ADDR_WIDTH-1:0] pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(1);

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int LEN_HI  = INS_WIDTH - OP_WIDTH - 1;
  localparam int MID_HI  = INS_WIDTH - OP_WIDTH - LEN_WIDTH - 1;
  localparam int MID_LO  = 3 * ADDR_WIDTH;

  logic [2:0]                state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                      wrap_err_q, wrap_err_d;
  logic [OP_WIDTH-1:0]       ir_op_q, ir_op_d;
  logic [LEN_WIDTH-1:0]      ir_len_q, ir_len_d;
  logic [ADDR_WIDTH-1:0]     ir_a_q, ir_a_d, ir_b_q, ir_b_d, ir_r_q, ir_r_d;
  logic [LEN_WIDTH-1:0]      row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]     cur_a_q, cur_a_d, cur_b_q, cur_b_d, cur_r_q, cur_r_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [OP_WIDTH-1:0]       last_op_q, last_op_d;
  logic [ADDR_WIDTH-1:0]     last_a_q, last_a_d, last_b_q, last_b_d, last_r_q, last_r_d;

  // Instruction bits between len and the address fields carry nothing for this block.
  logic unused_bits;
  if (MID_HI >= MID_LO) begin : g_mid
    assign unused_bits = ^{ins_rd_data[MID_HI:MID_LO], 1'(PE_COUNT)};
  end else begin : g_nomid
    assign unused_bits = 1'(PE_COUNT);
  end

  // Issue outputs show the live row when issuing and otherwise hold the last issued row.
  assign op_valid    = (state_q == S_EXEC) && !stall;
  assign op_code     = op_valid ? ir_op_q : last_op_q;
  assign addr_a      = op_valid ? cur_a_q : last_a_q;
  assign addr_b      = op_valid ? cur_b_q : last_b_q;
  assign addr_r      = op_valid ? cur_r_q : last_r_q;
  assign ins_rd_en   = (state_q == S_FETCH) && !stall;
  assign ins_rd_addr = pc_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign wrap_err    = wrap_err_q;
  assign pc          = pc_q;

  // Next-state logic for the sequencing FSM, program counter and row walkers.
  // IDLE and DONE ignore stall so done stays a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wrap_err_d = wrap_err_q;
    ir_op_d    = ir_op_q;
    ir_len_d   = ir_len_q;
    ir_a_d     = ir_a_q;
    ir_b_d     = ir_b_q;
    ir_r_d     = ir_r_q;
    row_cnt_d  = row_cnt_q;
    cur_a_d    = cur_a_q;
    cur_b_d    = cur_b_q;
    cur_r_d    = cur_r_q;
    drain_d    = drain_q;
    last_op_d  = last_op_q;
    last_a_d   = last_a_q;
    last_b_d   = last_b_q;
    last_r_d   = last_r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          pc_d       = start_pc;
          wrap_err_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (!stall) state_d = S_WAIT;
      end
      S_WAIT: begin
        // BRAM output is only valid here, so capture regardless of stall.
        ir_op_d  = ins_rd_data[INS_WIDTH-1 -: OP_WIDTH];
        ir_len_d = ins_rd_data[LEN_HI -: LEN_WIDTH];
        ir_a_d   = ins_rd_data[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
        ir_b_d   = ins_rd_data[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
        ir_r_d   = ins_rd_data[ADDR_WIDTH-1:0];
        if (!stall) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!stall) begin
          if (ir_op_q == OP_HALT) begin
            state_d = S_DONE;
          end else if ((ir_op_q == OP_NOP) || (ir_len_q == '0)) begin
            // One bubble cycle keeps every non-issuing instruction at 4 cycles.
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            state_d   = S_EXEC;
            row_cnt_d = ir_len_q;
            cur_a_d   = ir_a_q;
            cur_b_d   = ir_b_q;
            cur_r_d   = ir_r_q;
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          last_op_d = ir_op_q;
          last_a_d  = cur_a_q;
          last_b_d  = cur_b_q;
          last_r_d  = cur_r_q;
          cur_a_d   = cur_a_q + ADDR_WIDTH'(1);
          cur_b_d   = cur_b_q + ADDR_WIDTH'(1);
          cur_r_d   = cur_r_q + ADDR_WIDTH'(1);
          row_cnt_d = row_cnt_q - LEN_WIDTH'(1);
          if (row_cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_W'(PIPE_LAT - 1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drain_q == '0) begin
            if (&pc_q) begin
              wrap_err_d = 1'b1;
              pc_d       = '0;
              state_d    = S_DONE;
            end else begin
              pc_d    = pc_q + INS_ADDR_WIDTH'(1);
              state_d = S_FETCH;
            end
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight work at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      wrap_err_q <= 1'b0;
      ir_op_q    <= '0;
      ir_len_q   <= '0;
      ir_a_q     <= '0;
      ir_b_q     <= '0;
      ir_r_q     <= '0;
      row_cnt_q  <= '0;
      cur_a_q    <= '0;
      cur_b_q    <= '0;
      cur_r_q    <= '0;
      drain_q    <= '0;
      last_op_q  <= '0;
      last_a_q   <= '0;
      last_b_q   <= '0;
      last_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wrap_err_q <= wrap_err_d;
      ir_op_q    <= ir_op_d;
      ir_len_q   <= ir_len_d;
      ir_a_q     <= ir_a_d;
      ir_b_q     <= ir_b_d;
      ir_r_q     <= ir_r_d;
      row_cnt_q  <= row_cnt_d;
      cur_a_q    <= cur_a_d;
      cur_b_q    <= cur_b_d;
      cur_r_q    <= cur_r_d;
      drain_q    <= drain_d;
      last_op_q  <= last_op_d;
      last_a_q   <= last_a_d;
      last_b_q   <= last_b_d;
      last_r_q   <= last_r_d;
    end
  end

endmodule

// File: tb/tb_simd_ins_sequencer.sv
// Bench for simd_ins_sequencer: table of single-instruction programs plus hand-built corner sequences.
// Expected rows go to a scoreboard queue when a program is loaded and are popped as rows issue.
// Cycle counts are measured from the clock edge that samples start.
module tb_simd_ins_sequencer;
  localparam int IW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [9:0]    start_pc;
  logic          stall;
  logic          ins_rd_en;
  logic [9:0]    ins_rd_addr;
  logic [IW-1:0] ins_rd_data = '0;
  logic          op_valid;
  logic [3:0]    op_code;
  logic [9:0]    addr_a, addr_b, addr_r;
  logic          busy, done, wrap_err;
  logic [9:0]    pc;

  always #5 clk = ~clk;

  simd_ins_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .stall(stall),
    .ins_rd_en(ins_rd_en), .ins_rd_addr(ins_rd_addr), .ins_rd_data(ins_rd_data),
    .op_valid(op_valid), .op_code(op_code), .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r),
    .busy(busy), .done(done), .wrap_err(wrap_err), .pc(pc)
  );

  // Instruction BRAM with one-cycle registered read.
  logic [IW-1:0] mem [0:1023];
  always @(posedge clk) if (ins_rd_en) ins_rd_data <= mem[ins_rd_addr];

  typedef struct {
    logic [3:0] op; int len; logic [9:0] a, b, r; logic [9:0] spc;
    int stall_after; int stall_len;
    int exp_done; int exp_first; logic [9:0] exp_pc;
  } vec_t;
  typedef struct { logic [3:0] op; logic [9:0] a, b, r; } row_t;

  row_t sb[$];
  row_t last_row;
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   done_cyc, first_cyc, fetch0, rows;

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [15:0] len,
                                      input logic [9:0] a, input logic [9:0] b, input logic [9:0] r);
    logic [IW-1:0] w;
    w = '0;
    w[63:60] = op; w[59:44] = len; w[29:20] = a; w[19:10] = b; w[9:0] = r;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rows(input logic [3:0] op, input int len,
                           input logic [9:0] a, input logic [9:0] b, input logic [9:0] r);
    for (int i = 0; i < len; i++) begin
      row_t e;
      e.op = op; e.a = a + 10'(i); e.b = b + 10'(i); e.r = r + 10'(i);
      sb.push_back(e);
    end
  endtask

  // Starts a program and monitors every cycle until done (or abort_rows issued, or timeout).
  task automatic run_prog(input logic [9:0] spc, input int stall_after, input int stall_len,
                          input int abort_rows);
    int cyc, left;
    bit trig;
    done_cyc = -1; first_cyc = -1; fetch0 = 0; rows = 0; left = 0; trig = 0; cyc = 0;
    @(posedge clk); #1; start = 1'b1; start_pc = spc;
    @(posedge clk); #1; start = 1'b0;
    forever begin
      if (!trig && stall_len > 0 && rows == stall_after) begin trig = 1; left = stall_len; end
      if (left > 0) begin stall = 1'b1; left--; end else stall = 1'b0;
      @(negedge clk);
      cyc++;
      if (ins_rd_en && ins_rd_addr == 10'h000) fetch0++;
      if (stall) chk("stall_quiet", {30'd0, ins_rd_en, op_valid}, 32'd0);
      if (op_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        rows++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_extra_row: got row addr_a=%0h, expected no row", addr_a);
        end else begin
          row_t e;
          e = sb.pop_front();
          chk("row_op", op_code, e.op);
          chk("row_a", addr_a, e.a);
          chk("row_b", addr_b, e.b);
          chk("row_r", addr_r, e.r);
          last_row = e;
        end
      end else begin
        chk("hold", {op_code, addr_a, addr_b, addr_r},
            {last_row.op, last_row.a, last_row.b, last_row.r});
      end
      if (done) begin done_cyc = cyc; break; end
      if (abort_rows >= 0 && rows == abort_rows) break;
      if (cyc > 600) begin
        checks++; errors++;
        $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
        break;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  task automatic after_done(input string name);
    @(negedge clk);
    chk({name, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    mem[v.spc]        = mk(v.op, 16'(v.len), v.a, v.b, v.r);
    mem[v.spc + 10'd1] = mk(4'd1, 16'd0, 10'd0, 10'd0, 10'd0);
    if (v.op >= 4'd2) push_rows(v.op, v.len, v.a, v.b, v.r);
    run_prog(v.spc, v.stall_after, v.stall_len, -1);
    chk({name, "_done_cyc"}, done_cyc, v.exp_done);
    chk({name, "_first"}, first_cyc, v.exp_first);
    chk({name, "_pc"}, pc, v.exp_pc);
    chk({name, "_wrap"}, wrap_err, 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
    after_done(name);
  endtask

  initial begin
    //          op    len  a       b       r       spc     st_after st_len done first pc
    vecs[0] = '{4'd2,  3, 10'h010, 10'h020, 10'h030, 10'h000, -1, 0, 13,  4, 10'h001};
    vecs[1] = '{4'd2,  3, 10'h010, 10'h020, 10'h030, 10'h000,  2, 5, 18,  4, 10'h001};
    vecs[2] = '{4'd5,  4, 10'h3FE, 10'h100, 10'h3FF, 10'h040, -1, 0, 14,  4, 10'h041};
    vecs[3] = '{4'hF,  1, 10'h000, 10'h000, 10'h000, 10'h100,  0, 2, 13,  6, 10'h101};
    vecs[4] = '{4'd3,  0, 10'h055, 10'h066, 10'h077, 10'h200, -1, 0,  8, -1, 10'h201};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    last_row = '{op: 4'd0, a: 10'd0, b: 10'd0, r: 10'd0};
    rst = 1'b1; start = 1'b0; start_pc = '0; stall = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {28'd0, ins_rd_en, op_valid, busy, done}, 32'd0);
    chk("rst_wrap_pc", {21'd0, wrap_err, pc}, 32'd0);
    chk("rst_issue", {op_code, addr_a, addr_b, addr_r}, 34'd0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // NOP, zero-length vector op, HALT: no rows, done on the 12th cycle after start.
    mem[10'h300] = mk(4'd0, 16'd7, 10'h1, 10'h2, 10'h3);
    mem[10'h301] = mk(4'd3, 16'd0, 10'h1, 10'h2, 10'h3);
    mem[10'h302] = mk(4'd1, 16'd0, 10'h0, 10'h0, 10'h0);
    run_prog(10'h300, -1, 0, -1);
    chk("nop_done_cyc", done_cyc, 12);
    chk("nop_first", first_cyc, -1);
    chk("nop_pc", pc, 10'h302);
    after_done("nop");

    // NOP at the last address: wrap error, no fetch at address 0.
    mem[10'h3FF] = mk(4'd0, 16'd0, 10'h0, 10'h0, 10'h0);
    mem[10'h000] = mk(4'd2, 16'd1, 10'h5, 10'h6, 10'h7);
    run_prog(10'h3FF, -1, 0, -1);
    chk("wrap_done_cyc", done_cyc, 5);
    chk("wrap_err_set", wrap_err, 1);
    chk("wrap_pc", pc, 10'h000);
    chk("wrap_no_fetch0", fetch0, 0);
    chk("wrap_no_rows", first_cyc, -1);
    after_done("wrap");
    chk("wrap_sticky", wrap_err, 1);
    run_vec(vecs[2], "rerun_after_wrap");

    // Reset in the middle of a long vector op, then a clean re-run.
    mem[10'h080] = mk(4'd4, 16'd100, 10'h100, 10'h200, 10'h300);
    mem[10'h081] = mk(4'd1, 16'd0, 10'h0, 10'h0, 10'h0);
    push_rows(4'd4, 100, 10'h100, 10'h200, 10'h300);
    run_prog(10'h080, -1, 0, 10);
    chk("pre_rst_rows", rows, 10);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {29'd0, op_valid, busy, done}, 32'd0);
    chk("midrst_pc", pc, 10'h000);
    sb.delete();
    last_row = '{op: 4'd0, a: 10'd0, b: 10'd0, r: 10'd0};
    @(posedge clk); #1; rst = 1'b0;
    run_vec(vecs[0], "rerun_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
